// File: rtl/truth_table_seq_if.sv
// Operand, result and serial-configuration handshake bundle for truth_table_seq.
// The master side drives operands and config bits; the slave side is the LUT block.
interface truth_table_seq_if #(
    parameter int N_IN = 3
);
    logic [N_IN-1:0] in;
    logic            in_valid;
    logic            in_ready;
    logic            out;
    logic            out_valid;
    logic            out_ready;
    logic            cfg_start;
    logic            cfg_valid;
    logic            cfg_bit;
    logic            cfg_busy;

    modport master (
        output in, in_valid, out_ready, cfg_start, cfg_valid, cfg_bit,
        input  in_ready, out, out_valid, cfg_busy
    );

    modport slave (
        input  in, in_valid, out_ready, cfg_start, cfg_valid, cfg_bit,
        output in_ready, out, out_valid, cfg_busy
    );
endinterface

// File: rtl/truth_table_seq.sv
// Sequential reprogrammable LUT: evaluates a 2**N_IN-entry truth table with a valid/ready result.
// Optional macro LUT_SETTLE_EN adds a SETTLE state that delays each result by SETTLE_CYC cycles.
module truth_table_seq #(
    parameter int                  N_IN       = 3,
    parameter logic [2**N_IN-1:0] TT_INIT    = 8'hA7,
    parameter int                  SETTLE_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    truth_table_seq_if.slave bus
);
    localparam int W     = 2**N_IN;
    localparam int CNT_W = (N_IN + 1 < 5) ? 5 : N_IN + 1;

    if (N_IN < 1 || N_IN > 6 || SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_param_check
        $error("truth_table_seq: parameter out of range");
    end

`ifdef LUT_SETTLE_EN
    typedef enum logic [1:0] {ST_RUN, ST_LOAD, ST_SETTLE} state_t;
`else
    typedef enum logic [1:0] {ST_RUN, ST_LOAD} state_t;
`endif

    state_t           state_q, state_d;
    logic [W-1:0]     table_q, table_d;
    logic [W-1:0]     shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             out_valid_q, out_valid_d;
`ifdef LUT_SETTLE_EN
    logic [7:0]       settle_q, settle_d;
    logic             pend_out_q, pend_out_d;
    logic             cfg_pend_q, cfg_pend_d;
`endif

    logic in_ready;
    logic accept;
    logic result;

    // Table MSB holds the entry for the all-zeros operand, so index with the inverted operand.
    assign result   = table_q[~bus.in];
    assign in_ready = !rst && (state_q == ST_RUN) && !bus.cfg_start
                      && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.cfg_busy  = (state_q == ST_LOAD);

    always_comb begin
        state_d     = state_q;
        table_d     = table_q;
        shadow_d    = shadow_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
`ifdef LUT_SETTLE_EN
        settle_d    = settle_q;
        pend_out_d  = pend_out_q;
        cfg_pend_d  = cfg_pend_q;
`endif

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_RUN: begin
                if (bus.cfg_start) begin
                    state_d  = ST_LOAD;
                    shadow_d = '0;
                    cnt_d    = '0;
                end else if (accept) begin
`ifdef LUT_SETTLE_EN
                    state_d    = ST_SETTLE;
                    settle_d   = 8'd0;
                    pend_out_d = result;
`else
                    out_d       = result;
                    out_valid_d = 1'b1;
`endif
                end
            end

            // A full shadow commits in the cycle after its last bit arrives.
            ST_LOAD: begin
                if (bus.cfg_start) begin
                    shadow_d = '0;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_W'(W)) begin
                    table_d = shadow_q;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else if (bus.cfg_valid) begin
                    shadow_d = {shadow_q[W-2:0], bus.cfg_bit};
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end

`ifdef LUT_SETTLE_EN
            ST_SETTLE: begin
                if (bus.cfg_start) begin
                    cfg_pend_d = 1'b1;
                end
                if (settle_q == 8'(SETTLE_CYC - 1)) begin
                    out_d       = pend_out_q;
                    out_valid_d = 1'b1;
                    settle_d    = 8'd0;
                    if (cfg_pend_q || bus.cfg_start) begin
                        state_d    = ST_LOAD;
                        shadow_d   = '0;
                        cnt_d      = '0;
                        cfg_pend_d = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
`endif

            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            table_q     <= TT_INIT;
            shadow_q    <= '0;
            cnt_q       <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef LUT_SETTLE_EN
            settle_q    <= 8'd0;
            pend_out_q  <= 1'b0;
            cfg_pend_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            table_q     <= table_d;
            shadow_q    <= shadow_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
`ifdef LUT_SETTLE_EN
            settle_q    <= settle_d;
            pend_out_q  <= pend_out_d;
            cfg_pend_q  <= cfg_pend_d;
`endif
        end
    end
endmodule
